mem_stage_unit: RTL

//  Consumer end of the EX/MEM pipeline register in the 32-bit MIPS pipeline.

---
 rtl/mem_stage_unit.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_unit.sv
// rtl/mem_stage_unit.sv - EX/MEM consumer: redirects, load/store handshake, MEM/WB register
// Two states: IDLE accepts an instruction, BUSY waits for memAck or the timeout.
module mem_stage_unit #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inValid,
    input  logic              inMemRead,
    input  logic              inMemWrite,
    input  logic              inBranch,
    input  logic              inJumpEn,
    input  logic              inRegWrite,
    input  logic              inZf,
    input  logic [DATA_W-1:0] inAdder,
    input  logic [DATA_W-1:0] inJump,
    input  logic [DATA_W-1:0] inOutAlu,
    input  logic [DATA_W-1:0] inRD2,
    input  logic [REG_W-1:0]  inMux5b,
    output logic              memReq,
    output logic              memWe,
    output logic [DATA_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic [DATA_W-1:0] memRData,
    input  logic              memAck,
    output logic              stall,
    output logic              pcRedirect,
    output logic [DATA_W-1:0] pcTarget,
    output logic              outValid,
    output logic [DATA_W-1:0] outWbData,
    output logic [REG_W-1:0]  outMux5b,
    output logic              outRegWrite,
    output logic              outErr
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [DATA_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               pc_redirect_q, pc_redirect_d;
    logic [DATA_W-1:0]  pc_target_q, pc_target_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_wb_data_q, out_wb_data_d;
    logic [REG_W-1:0]   out_mux5b_q, out_mux5b_d;
    logic               out_reg_write_q, out_reg_write_d;
    logic               out_err_q, out_err_d;
    logic [REG_W-1:0]   dest_q, dest_d;
    logic               rw_lat_q, rw_lat_d;

    logic mem_op;
    logic misaligned;
    logic timeout;

    assign mem_op     = inMemRead | inMemWrite;
    assign misaligned = mem_op & (inOutAlu[1:0] != 2'b00);
    assign timeout    = (state_q == BUSY) & ~memAck & (cnt_q == CNT_LAST);

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        mem_req_d       = mem_req_q;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        pc_redirect_d   = 1'b0;
        pc_target_d     = pc_target_q;
        out_valid_d     = 1'b0;
        out_wb_data_d   = out_wb_data_q;
        out_mux5b_d     = out_mux5b_q;
        out_reg_write_d = 1'b0;
        out_err_d       = 1'b0;
        dest_d          = dest_q;
        rw_lat_d        = rw_lat_q;
        stall           = 1'b0;

        case (state_q)
            IDLE: begin
                if (inValid) begin
                    if (inJumpEn | (inBranch & inZf)) begin
                        pc_redirect_d = 1'b1;
                        pc_target_d   = inJumpEn ? inJump : inAdder;
                    end
                    if (!mem_op) begin
                        out_valid_d     = 1'b1;
                        out_wb_data_d   = inOutAlu;
                        out_mux5b_d     = inMux5b;
                        out_reg_write_d = inRegWrite;
                    end else if (misaligned) begin
                        out_valid_d = 1'b1;
                        out_err_d   = 1'b1;
                    end else begin
                        stall       = 1'b1;
                        state_d     = BUSY;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = inMemWrite;
                        mem_addr_d  = inOutAlu;
                        mem_wdata_d = inRD2;
                        dest_d      = inMux5b;
                        rw_lat_d    = inRegWrite;
                    end
                end
            end
            BUSY: begin
                if (memAck) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    out_valid_d = 1'b1;
                    out_mux5b_d = dest_q;
                    // Stores report their address as write-back data but never write a register.
                    if (mem_we_q) begin
                        out_wb_data_d = mem_addr_q;
                    end else begin
                        out_wb_data_d   = memRData;
                        out_reg_write_d = rw_lat_q;
                    end
                end else if (timeout) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    out_valid_d = 1'b1;
                    out_err_d   = 1'b1;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            pc_redirect_q   <= 1'b0;
            pc_target_q     <= '0;
            out_valid_q     <= 1'b0;
            out_wb_data_q   <= '0;
            out_mux5b_q     <= '0;
            out_reg_write_q <= 1'b0;
            out_err_q       <= 1'b0;
            dest_q          <= '0;
            rw_lat_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            mem_req_q       <= mem_req_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            pc_redirect_q   <= pc_redirect_d;
            pc_target_q     <= pc_target_d;
            out_valid_q     <= out_valid_d;
            out_wb_data_q   <= out_wb_data_d;
            out_mux5b_q     <= out_mux5b_d;
            out_reg_write_q <= out_reg_write_d;
            out_err_q       <= out_err_d;
            dest_q          <= dest_d;
            rw_lat_q        <= rw_lat_d;
        end
    end

    assign memReq      = mem_req_q;
    assign memWe       = mem_we_q;
    assign memAddr     = mem_addr_q;
    assign memWData    = mem_wdata_q;
    assign pcRedirect  = pc_redirect_q;
    assign pcTarget    = pc_target_q;
    assign outValid    = out_valid_q;
    assign outWbData   = out_wb_data_q;
    assign outMux5b    = out_mux5b_q;
    assign outRegWrite = out_reg_write_q;
    assign outErr      = out_err_q;

endmodule
